// File: rtl/frame_scanout_pkg.sv
// frame_scanout_pkg: VGA 640x480@60 timing constants and framebuffer geometry
// shared by the scanout and the renderer.
package frame_scanout_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int FB_AW = 15;
    localparam int CNT_W = 11;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef struct packed {
        logic vis;
        logic hs_n;
        logic vs_n;
    } pix_flags_t;

    localparam pix_flags_t FLAGS_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // Row stride of 160 built from shifts: 160 = 128 + 32.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_AW-1:0] vy, input logic [FB_AW-1:0] hx);
        return (vy << 7) + (vy << 5) + hx;
    endfunction

endpackage

// File: rtl/frame_scanout_if.sv
// frame_scanout_if: framebuffer read port plus VGA output signals of the scanout.
interface frame_scanout_if;
    import frame_scanout_pkg::*;

    logic [FB_AW-1:0] rd_addr;
    logic             rd_en;
    logic [2:0]       rd_data;
    logic [2:0]       vga_colour;
    logic             vga_hs;
    logic             vga_vs;
    logic             vga_blank_n;
    logic             frame_start;
    logic             vblank_start;

    modport master (
        output rd_addr, rd_en, vga_colour, vga_hs, vga_vs, vga_blank_n, frame_start, vblank_start,
        input  rd_data
    );

    modport slave (
        input  rd_addr, rd_en, vga_colour, vga_hs, vga_vs, vga_blank_n, frame_start, vblank_start,
        output rd_data
    );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-phase divider, h/v raster counters and sync/visible decode.
module vga_timing_gen
    import frame_scanout_pkg::*;
#(
    parameter int H_VIS = H_VISIBLE,
    parameter int H_FP  = H_FRONT,
    parameter int H_SW  = H_SYNC,
    parameter int H_BP  = H_BACK,
    parameter int V_VIS = V_VISIBLE,
    parameter int V_FP  = V_FRONT,
    parameter int V_SW  = V_SYNC,
    parameter int V_BP  = V_BACK
) (
    input  logic             clk,
    input  logic             reset,
    output logic             o_adv,
    output logic [CNT_W-1:0] o_h,
    output logic [CNT_W-1:0] o_v,
    output logic             o_visible,
    output logic             o_hs_n,
    output logic             o_vs_n,
    output logic             o_first,
    output logic             o_vblank
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [CNT_W-1:0] H_VEND = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] H_SBEG = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_SEND = CNT_W'(H_VIS + H_FP + H_SW);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [CNT_W-1:0] V_VEND = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] V_SBEG = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_SEND = CNT_W'(V_VIS + V_FP + V_SW);

    logic             r_phase;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = r_h == H_LAST;
    assign w_v_wrap = r_v == V_LAST;

    // The raster moves at half the clock rate; phase=1 marks the advance edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                r_h <= w_h_wrap ? '0 : r_h + 1'b1;
                if (w_h_wrap)
                    r_v <= w_v_wrap ? '0 : r_v + 1'b1;
            end
        end
    end

    assign o_adv     = r_phase;
    assign o_h       = r_h;
    assign o_v       = r_v;
    assign o_visible = (r_h < H_VEND) && (r_v < V_VEND);
    assign o_hs_n    = !((r_h >= H_SBEG) && (r_h < H_SEND));
    assign o_vs_n    = !((r_v >= V_SBEG) && (r_v < V_SEND));
    assign o_first   = (r_h == '0) && (r_v == '0);
    assign o_vblank  = (r_h == '0) && (r_v == V_VEND);

endmodule

// File: rtl/frame_scanout.sv
// frame_scanout: reads a 160x120 framebuffer with 4x4 pixel replication and
// drives VGA colour/sync, compensating the one-cycle RAM latency with a flag pipeline.
module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int H_VIS       = H_VISIBLE,
    parameter int V_VIS       = V_VISIBLE,
    parameter int SCALE_SHIFT = 2,
    parameter int H_FP        = H_FRONT,
    parameter int H_SW        = H_SYNC,
    parameter int H_BP        = H_BACK,
    parameter int V_FP        = V_FRONT,
    parameter int V_SW        = V_SYNC,
    parameter int V_BP        = V_BACK
) (
    input  logic            clk,
    input  logic            reset,
    frame_scanout_if.master bus
);

    logic             w_adv;
    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic             w_visible;
    logic             w_hs_n;
    logic             w_vs_n;
    logic             w_first;
    logic             w_vblank;
    logic [FB_AW-1:0] w_hx;
    logic [FB_AW-1:0] w_vy;
    pix_flags_t       w_flags;

    vga_timing_gen #(
        .H_VIS (H_VIS),
        .H_FP  (H_FP),
        .H_SW  (H_SW),
        .H_BP  (H_BP),
        .V_VIS (V_VIS),
        .V_FP  (V_FP),
        .V_SW  (V_SW),
        .V_BP  (V_BP)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .o_adv     (w_adv),
        .o_h       (w_h),
        .o_v       (w_v),
        .o_visible (w_visible),
        .o_hs_n    (w_hs_n),
        .o_vs_n    (w_vs_n),
        .o_first   (w_first),
        .o_vblank  (w_vblank)
    );

    assign w_hx    = FB_AW'(w_h >> SCALE_SHIFT);
    assign w_vy    = FB_AW'(w_v >> SCALE_SHIFT);
    assign w_flags = '{vis: w_visible, hs_n: w_hs_n, vs_n: w_vs_n};

    logic [FB_AW-1:0] r_addr;
    pix_flags_t       r_s0;
    pix_flags_t       r_s1;
    pix_flags_t       r_out;
    logic [2:0]       r_colour;
    logic             r_frame_start;
    logic             r_vblank_start;

    // r_s0 is captured with the address; r_s1/r_out shift every clk so the
    // flags land two clocks later, alongside the RAM data for that pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr         <= '0;
            r_s0           <= FLAGS_IDLE;
            r_s1           <= FLAGS_IDLE;
            r_out          <= FLAGS_IDLE;
            r_colour       <= COLOUR_BLACK;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            r_frame_start  <= w_adv && w_first;
            r_vblank_start <= w_adv && w_vblank;
            r_s1           <= r_s0;
            r_out          <= r_s1;
            r_colour       <= r_s1.vis ? bus.rd_data : COLOUR_BLACK;
            if (w_adv) begin
                r_s0 <= w_flags;
                if (w_visible)
                    r_addr <= fb_addr(w_vy, w_hx);
            end
        end
    end

    assign bus.rd_addr      = r_addr;
    assign bus.rd_en        = r_s0.vis;
    assign bus.vga_colour   = r_colour;
    assign bus.vga_hs       = r_out.hs_n;
    assign bus.vga_vs       = r_out.vs_n;
    assign bus.vga_blank_n  = r_out.vis;
    assign bus.frame_start  = r_frame_start;
    assign bus.vblank_start = r_vblank_start;

endmodule

// File: doc/frame_scanout.md
FRAME_SCANOUT -- requirements
Module: frame_scanout

Interface
REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_VIS, default 480, visible lines per frame.
REQ-003 SHALL have parameter SCALE_SHIFT, default 2, log2 of the pixel replication factor (4x4 gives 160x120).
REQ-004 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rd_addr, output, 15, framebuffer read address = y*160 + x.
REQ-007 SHALL have port rd_en, output, 1, read strobe, high only for visible pixels.
REQ-008 SHALL have port rd_data, input, 3, framebuffer colour with 1-clk synchronous latency after rd_addr/rd_en.
REQ-009 SHALL have port vga_colour, output, 3, {R,G,B}, 1 bit per channel.
REQ-010 SHALL have port vga_hs, output, 1, horizontal sync, active-low.
REQ-011 SHALL have port vga_vs, output, 1, vertical sync, active-low.
REQ-012 SHALL have port vga_blank_n, output, 1, low outside the visible area.
REQ-013 SHALL have port frame_start, output, 1, 1-clk pulse when the (0,0) pixel is issued.
REQ-014 SHALL have port vblank_start, output, 1, 1-clk pulse when (0,V_VIS) is issued; this is the renderer's safe-write window start.

Function
REQ-015 SHALL toggle a pixel-phase bit every clk; counters advance only on cycles with phase=1 (25 MHz pixel rate).
REQ-016 SHALL count h over 0..799 and v over 0..524: visible 640/480, front porch 16/10, sync 96/2, back porch 48/33.
REQ-017 SHALL wrap h 799->0 with v+1, and wrap v 524->0 on the same edge.
REQ-018 SHALL on each advance edge E register rd_addr = (v>>2)*160 + (h>>2) for the current (h,v), computed as (vy<<7)+(vy<<5)+hx with 15-bit arithmetic.
REQ-019 SHALL at the same edge E set rd_en = (h<640 && v<480); outside the visible area rd_addr holds its last value.
REQ-020 SHALL present vga_colour/vga_hs/vga_vs/vga_blank_n for that pixel at edge E+2 and hold them for 2 clk, via a 2-stage delay of the visible/sync flags.
REQ-021 SHALL drive vga_colour = rd_data when the delayed visible flag is 1, else 3'b000 regardless of rd_data.
REQ-022 SHALL hold vga_hs low for h in 656..751 and vga_vs low for v in 490..491.
REQ-023 SHALL assert frame_start and vblank_start at edge E of the corresponding pixel, i.e. aligned with rd_addr, not with the VGA outputs.
REQ-024 SHALL give a maximum address of 19199 at (639,479); no address >= 19200 is ever issued with rd_en=1.

Reset
REQ-025 SHALL, while reset=1, immediately force h=0, v=0, phase=0, rd_addr=0, rd_en=0, vga_colour=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0, vblank_start=0, and clear the delay pipeline.
REQ-026 SHALL, after deassertion, issue pixel (0,0) with frame_start on the second rising edge; a reset mid-line or mid-frame restarts cleanly from (0,0) with no partial-line artefact.

Structure
REQ-027 SHALL take timing constants (porch, sync, total values) and framebuffer dimensions 160/120 from the shared game defines include, also used by the renderer.
REQ-028 SHALL implement the h/v counters and sync decode in one sub-module, vga_timing_gen; the address/pipeline logic stays in frame_scanout.

Verification
REQ-029 SHALL cover: reset release -> rd_addr=0, rd_en=1, frame_start=1 on the 2nd edge; vga_blank_n=1 two clk later.
REQ-030 SHALL cover: address mapping -> h=4..7,v=0 gives rd_addr=1; h=0,v=4 gives 160; h=639,v=479 gives 19199; h=640 gives rd_en=0.
REQ-031 SHALL cover: line timing -> hs low for exactly 192 clk, line period 1600 clk; vs low for 3200 clk, frame period 840000 clk, with exactly one frame_start and one vblank_start per frame.
REQ-032 SHALL cover: colour path -> a RAM model returning 3'b101 at a visible pixel gives vga_colour=101 at E+2; returning 3'b111 during blanking gives vga_colour=000.
REQ-033 SHALL cover: reset asserted at h=300,v=100 -> all outputs take reset values within the same cycle (async); after release, the sequence restarts at (0,0) with correct periods.
